// File: rtl/serial_frame_router.sv
// serial_frame_router
//   Bit-serial frame receiver/router. Hunts serIn for a start pattern, then
//   shifts in a channel address and a payload length (both MSB first), and
//   forwards the next L payload bits from serIn to the addressed channel.
//
//   Optional feature macro: ROUTER_PARITY_EN
//     defined   -> one even-parity bit follows the payload (or the length field
//                  when L=0). Parity covers addr, len and payload bits.
//     undefined -> no parity state or accumulator; parityErr is tied low.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous, active-low reset
//   serIn      in   1    serial input, one bit per clock
//   serOut     out  NCH  per-channel serial out; routed channel = serIn, others z
//   outValid   out  NCH  one-hot-or-zero; bit a high while channel a carries payload
//   busy       out  1    high whenever a frame is being received
//   frameDone  out  1    one-cycle registered pulse after the last bit of a frame
//   parityErr  out  1    one-cycle pulse with frameDone on parity mismatch
//
// States
//   S_SEARCH  | hunting for the start pattern (overlapping match)
//   S_ADDR    | shifting in ADDR_W address bits
//   S_LEN     | shifting in LEN_W length bits, loading the payload counter
//   S_PAYLOAD | forwarding L payload bits to channel addr
//   S_PARITY  | sampling the parity bit (ROUTER_PARITY_EN only)

module serial_frame_router #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter int                   ADDR_W    = 2,
  parameter int                   LEN_W     = 4,
  localparam int                  NCH       = 2**ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           serIn,
  output logic [NCH-1:0] serOut,
  output logic [NCH-1:0] outValid,
  output logic           busy,
  output logic           frameDone,
  output logic           parityErr
);

  localparam int MAXF = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int FW   = $clog2(MAXF + 1);

  typedef enum logic [2:0] {
    S_SEARCH,
    S_ADDR,
    S_LEN,
    S_PAYLOAD
`ifdef ROUTER_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                 state, state_nx;
  logic [PATTERN_W-1:0]   hist, hist_nx;
  logic [ADDR_W-1:0]      addr, addr_nx;
  logic [LEN_W-1:0]       len, len_nx;
  logic [LEN_W-1:0]       cnt, cnt_nx;
  logic [FW-1:0]          fcnt, fcnt_nx;
  logic                   done_q, done_nx;
  logic [PATTERN_W-1:0]   window;
  logic [LEN_W-1:0]       len_full;
  logic [NCH-1:0]         route;

  // Window is the history with the live bit appended; the oldest bit falls off.
  assign window   = PATTERN_W'({hist, serIn});
  assign len_full = LEN_W'({len, serIn});

`ifdef ROUTER_PARITY_EN
  logic par, par_nx;
  logic perr_q, perr_nx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_SEARCH;
      hist   <= '0;
      addr   <= '0;
      len    <= '0;
      cnt    <= '0;
      fcnt   <= '0;
      done_q <= 1'b0;
`ifdef ROUTER_PARITY_EN
      par    <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      hist   <= hist_nx;
      addr   <= addr_nx;
      len    <= len_nx;
      cnt    <= cnt_nx;
      fcnt   <= fcnt_nx;
      done_q <= done_nx;
`ifdef ROUTER_PARITY_EN
      par    <= par_nx;
      perr_q <= perr_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    addr_nx  = addr;
    len_nx   = len;
    cnt_nx   = cnt;
    fcnt_nx  = fcnt;
    done_nx  = 1'b0;
`ifdef ROUTER_PARITY_EN
    par_nx   = par;
    perr_nx  = 1'b0;
`endif
    case (state)
      S_SEARCH: begin
        hist_nx = window;
        if (window == PATTERN) begin
          // History is cleared so a following frame needs a full fresh pattern.
          state_nx = S_ADDR;
          hist_nx  = '0;
          fcnt_nx  = '0;
`ifdef ROUTER_PARITY_EN
          par_nx   = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        addr_nx = ADDR_W'({addr, serIn});
        fcnt_nx = fcnt + 1'b1;
`ifdef ROUTER_PARITY_EN
        par_nx  = par ^ serIn;
`endif
        if (fcnt == FW'(ADDR_W - 1)) begin
          state_nx = S_LEN;
          fcnt_nx  = '0;
        end
      end
      S_LEN: begin
        len_nx  = len_full;
        fcnt_nx = fcnt + 1'b1;
`ifdef ROUTER_PARITY_EN
        par_nx  = par ^ serIn;
`endif
        if (fcnt == FW'(LEN_W - 1)) begin
          fcnt_nx = '0;
          cnt_nx  = len_full;
          if (len_full != '0) begin
            state_nx = S_PAYLOAD;
          end else begin
`ifdef ROUTER_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_SEARCH;
            done_nx  = 1'b1;
`endif
          end
        end
      end
      S_PAYLOAD: begin
        cnt_nx = cnt - 1'b1;
`ifdef ROUTER_PARITY_EN
        par_nx = par ^ serIn;
`endif
        if (cnt == LEN_W'(1)) begin
`ifdef ROUTER_PARITY_EN
          state_nx = S_PARITY;
`else
          state_nx = S_SEARCH;
          done_nx  = 1'b1;
`endif
        end
      end
`ifdef ROUTER_PARITY_EN
      S_PARITY: begin
        state_nx = S_SEARCH;
        done_nx  = 1'b1;
        perr_nx  = par ^ serIn;
      end
`endif
      default: state_nx = S_SEARCH;
    endcase
  end

  // Routing is decoded from state, so an async reset drops it immediately.
  assign route     = (state == S_PAYLOAD) ? (NCH'(1) << addr) : '0;
  assign outValid  = route;
  assign busy      = (state != S_SEARCH);
  assign frameDone = done_q;

`ifdef ROUTER_PARITY_EN
  assign parityErr = perr_q;
`else
  assign parityErr = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign serOut[g] = route[g] ? serIn : 1'bz;
  end

endmodule
